// File: rtl/ula_arbitro_2req_pkg.sv
// Shared definitions for the two-requester ALU sequencer: states, opcodes and
// the opcode/operand screening used before an operation reaches the ALU.
package ula_arbitro_2req_pkg;

    localparam logic [1:0] OCIOSO   = 2'd0;
    localparam logic [1:0] EXECUTA  = 2'd1;
    localparam logic [1:0] RESPOSTA = 2'd2;

    localparam logic [3:0] OP_SOMA  = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_MUL   = 4'b0010;
    localparam logic [3:0] OP_DIV   = 4'b0011;
    localparam logic [3:0] OP_RESTO = 4'b0100;
    localparam logic [3:0] OP_AND   = 4'b0110;
    localparam logic [3:0] OP_OR    = 4'b0111;
    localparam logic [3:0] OP_NAND  = 4'b1000;
    localparam logic [3:0] OP_NOR   = 4'b1001;
    localparam logic [3:0] OP_XOR   = 4'b1010;
    localparam logic [3:0] OP_NOT   = 4'b1011;

    typedef struct packed {
        logic        id;
        logic [15:0] resultado;
        logic        maior;
        logic        menor;
        logic        igual;
        logic        erro;
    } resp_t;

    function automatic logic op_valido(input logic [3:0] op);
        case (op)
            OP_SOMA, OP_SUB, OP_MUL, OP_DIV, OP_RESTO,
            OP_AND, OP_OR, OP_NAND, OP_NOR, OP_XOR, OP_NOT: return 1'b1;
            default:                                        return 1'b0;
        endcase
    endfunction

    // Undefined opcodes and division/remainder by zero never reach the ALU.
    function automatic logic op_rejeitado(input logic [3:0] op, input logic [7:0] b);
        return !op_valido(op) || ((op == OP_DIV || op == OP_RESTO) && b == 8'd0);
    endfunction

endpackage

// File: rtl/ula_arbitro_2req_arbitro_rr_2.sv
// Two-way round-robin arbiter: one-hot grant, priority flips to the other
// requester after every grant.
module arbitro_rr_2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    input  logic       enable,
    output logic [1:0] grant
);

    logic prioridade;

    always_comb begin
        grant = 2'b00;
        if (enable) begin
            if (valid[0] && valid[1]) grant = prioridade ? 2'b10 : 2'b01;
            else                      grant = valid;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         prioridade <= 1'b0;
        else if (|grant) prioridade <= grant[0];
    end

endmodule

// File: rtl/ula_arbitro_2req.sv
// Shares one 8-bit ALU between two requesters: accept, hold ALU inputs for
// LATENCIA cycles, capture result and flags, return a tagged response.
module ula_arbitro_2req
    import ula_arbitro_2req_pkg::*;
#(
    parameter int LATENCIA = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [7:0]  req0_a,
    input  logic [7:0]  req0_b,
    input  logic [3:0]  req0_op,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [7:0]  req1_a,
    input  logic [7:0]  req1_b,
    input  logic [3:0]  req1_op,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        resp_id,
    output logic [15:0] resp_resultado,
    output logic        resp_maior,
    output logic        resp_menor,
    output logic        resp_igual,
    output logic        resp_erro,
    output logic [7:0]  ula_a,
    output logic [7:0]  ula_b,
    output logic [3:0]  ula_sel_op,
    input  logic [15:0] ula_resultado,
    input  logic        ula_maior,
    input  logic        ula_menor,
    input  logic        ula_igual
);

    localparam logic [3:0] ULTIMO = 4'(LATENCIA - 1);

    logic [1:0] estado;
    logic [3:0] contador;
    logic [1:0] grant;
    logic [7:0] a_sel;
    logic [7:0] b_sel;
    logic [3:0] op_sel;
    resp_t      resp;

    // Gating the enable with rst keeps both ready outputs low during reset.
    arbitro_rr_2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .valid  ({req1_valid, req0_valid}),
        .enable (estado == OCIOSO && !rst),
        .grant  (grant)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign a_sel  = grant[1] ? req1_a  : req0_a;
    assign b_sel  = grant[1] ? req1_b  : req0_b;
    assign op_sel = grant[1] ? req1_op : req0_op;

    assign resp_id        = resp.id;
    assign resp_resultado = resp.resultado;
    assign resp_maior     = resp.maior;
    assign resp_menor     = resp.menor;
    assign resp_igual     = resp.igual;
    assign resp_erro      = resp.erro;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado     <= OCIOSO;
            contador   <= '0;
            resp_valid <= 1'b0;
            resp       <= '0;
            ula_a      <= '0;
            ula_b      <= '0;
            ula_sel_op <= '0;
        end else begin
            case (estado)
                OCIOSO: begin
                    if (|grant) begin
                        resp.id <= grant[1];
                        // Rejected ops leave the ALU inputs untouched.
                        if (op_rejeitado(op_sel, b_sel)) begin
                            resp.resultado <= '0;
                            resp.maior     <= 1'b0;
                            resp.menor     <= 1'b0;
                            resp.igual     <= 1'b0;
                            resp.erro      <= 1'b1;
                            resp_valid     <= 1'b1;
                            estado         <= RESPOSTA;
                        end else begin
                            ula_a      <= a_sel;
                            ula_b      <= b_sel;
                            ula_sel_op <= op_sel;
                            contador   <= '0;
                            estado     <= EXECUTA;
                        end
                    end
                end
                EXECUTA: begin
                    if (contador == ULTIMO) begin
                        resp.resultado <= ula_resultado;
                        resp.maior     <= ula_maior;
                        resp.menor     <= ula_menor;
                        resp.igual     <= ula_igual;
                        resp.erro      <= 1'b0;
                        resp_valid     <= 1'b1;
                        estado         <= RESPOSTA;
                    end else begin
                        contador <= contador + 4'd1;
                    end
                end
                RESPOSTA: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        estado     <= OCIOSO;
                    end
                end
                default: estado <= OCIOSO;
            endcase
        end
    end

endmodule

// File: tb/tb_ula_arbitro_2req.sv
// Bench for ula_arbitro_2req: two instances (LATENCIA 1 and 4) driven side by
// side, each with a behavioural ALU, a request driver and a response scoreboard.
module tb_ula_arbitro_2req;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] op;
    } req_t;

    typedef struct {
        logic        id;
        logic [15:0] res;
        logic        gt, lt, eq, err;
        logic [7:0]  ua, ub;
        logic [3:0]  uop;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst        [2];
    logic        v          [2][2];
    logic        rdy        [2][2];
    logic [7:0]  a          [2][2];
    logic [7:0]  b          [2][2];
    logic [3:0]  op         [2][2];
    logic        resp_valid [2];
    logic        resp_ready [2];
    logic        resp_id    [2];
    logic [15:0] resp_res   [2];
    logic        resp_maior [2];
    logic        resp_menor [2];
    logic        resp_igual [2];
    logic        resp_erro  [2];
    logic [7:0]  ula_a      [2];
    logic [7:0]  ula_b      [2];
    logic [3:0]  ula_op     [2];
    logic [15:0] ula_res    [2];
    logic        ula_gt     [2];
    logic        ula_lt     [2];
    logic        ula_eq     [2];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference ALU behaviour, straight from the opcode table.
    function automatic logic [15:0] ref_res(logic [7:0] x, logic [7:0] y, logic [3:0] o);
        int ix, iy;
        ix = x;
        iy = y;
        case (o)
            4'd0:  return 16'(ix + iy);
            4'd1:  return 16'(ix - iy);
            4'd2:  return 16'(ix * iy);
            4'd3:  return (iy == 0) ? 16'h0 : 16'(ix / iy);
            4'd4:  return (iy == 0) ? 16'h0 : 16'(ix % iy);
            4'd6:  return {8'h0, x & y};
            4'd7:  return {8'h0, x | y};
            4'd8:  return {8'h0, ~(x & y)};
            4'd9:  return {8'h0, ~(x | y)};
            4'd10: return {8'h0, x ^ y};
            4'd11: return {8'h0, ~x};
            default: return 16'h0;
        endcase
    endfunction

    function automatic logic ref_err(logic [7:0] y, logic [3:0] o);
        int io;
        io = o;
        return io == 5 || io >= 12 || ((io == 3 || io == 4) && y == 8'd0);
    endfunction

    function automatic int lat(int l);
        return (l == 0) ? 1 : 4;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : lane
        ula_arbitro_2req #(.LATENCIA(g == 0 ? 1 : 4)) dut (
            .clk            (clk),
            .rst            (rst[g]),
            .req0_valid     (v[g][0]),
            .req0_ready     (rdy[g][0]),
            .req0_a         (a[g][0]),
            .req0_b         (b[g][0]),
            .req0_op        (op[g][0]),
            .req1_valid     (v[g][1]),
            .req1_ready     (rdy[g][1]),
            .req1_a         (a[g][1]),
            .req1_b         (b[g][1]),
            .req1_op        (op[g][1]),
            .resp_valid     (resp_valid[g]),
            .resp_ready     (resp_ready[g]),
            .resp_id        (resp_id[g]),
            .resp_resultado (resp_res[g]),
            .resp_maior     (resp_maior[g]),
            .resp_menor     (resp_menor[g]),
            .resp_igual     (resp_igual[g]),
            .resp_erro      (resp_erro[g]),
            .ula_a          (ula_a[g]),
            .ula_b          (ula_b[g]),
            .ula_sel_op     (ula_op[g]),
            .ula_resultado  (ula_res[g]),
            .ula_maior      (ula_gt[g]),
            .ula_menor      (ula_lt[g]),
            .ula_igual      (ula_eq[g])
        );
        assign ula_res[g] = ref_res(ula_a[g], ula_b[g], ula_op[g]);
        assign ula_gt[g]  = ula_a[g] >  ula_b[g];
        assign ula_lt[g]  = ula_a[g] <  ula_b[g];
        assign ula_eq[g]  = ula_a[g] == ula_b[g];
    end

    // Model state.
    exp_t       sb       [2][$];
    req_t       pend     [2][2][$];
    logic       acc_flag [2][2];
    int         acc_cnt  [2];
    int         hs_cnt   [2];
    int         drop_cnt [2];
    int         rst_at   [2];
    logic       prio     [2];
    logic [7:0] last_a   [2];
    logic [7:0] last_b   [2];
    logic [3:0] last_op  [2];
    int         rr_mode;
    logic       reset_arm;

    task automatic check(string name, int l, logic [63:0] act, logic [63:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s lane%0d cycle %0d: got %0h expected %0h", name, l, cyc, act, expv);
        end
    endtask

    function automatic logic [43:0] outs(int l);
        return {rdy[l][0], rdy[l][1], resp_valid[l], resp_id[l], resp_res[l], resp_maior[l],
                resp_menor[l], resp_igual[l], resp_erro[l], ula_a[l], ula_b[l], ula_op[l]};
    endfunction

    function automatic logic busy(int l);
        return (acc_cnt[l] - drop_cnt[l]) != hs_cnt[l];
    endfunction

    function automatic logic idle();
        for (int l = 0; l < 2; l++) begin
            if (busy(l) || sb[l].size() != 0 || v[l][0] || v[l][1] ||
                pend[l][0].size() != 0 || pend[l][1].size() != 0 || rst[l])
                return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic accept(int l, int r);
        exp_t e;
        e.id  = 1'(r);
        e.err = ref_err(b[l][r], op[l][r]);
        if (e.err) begin
            e.res = 16'h0;
            e.gt  = 1'b0;
            e.lt  = 1'b0;
            e.eq  = 1'b0;
            e.due = cyc + 1;
        end else begin
            e.res      = ref_res(a[l][r], b[l][r], op[l][r]);
            e.gt       = a[l][r] >  b[l][r];
            e.lt       = a[l][r] <  b[l][r];
            e.eq       = a[l][r] == b[l][r];
            e.due      = cyc + 1 + lat(l);
            last_a[l]  = a[l][r];
            last_b[l]  = b[l][r];
            last_op[l] = op[l][r];
        end
        e.ua  = last_a[l];
        e.ub  = last_b[l];
        e.uop = last_op[l];
        sb[l].push_back(e);
        acc_cnt[l]++;
        prio[l]        = (r == 0);
        acc_flag[l][r] = 1'b1;
        if (reset_arm) rst_at[l] = cyc + ((lat(l) > 1) ? 2 : 1);
    endtask

    task automatic step();
        logic e0, e1;
        @(posedge clk);
        #1;
        for (int l = 0; l < 2; l++) begin
            if (cyc == rst_at[l]) begin
                rst[l]         = 1'b1;
                v[l][0]        = 1'b0;
                v[l][1]        = 1'b0;
                acc_flag[l][0] = 1'b0;
                acc_flag[l][1] = 1'b0;
                sb[l].delete();
                drop_cnt[l] = acc_cnt[l] - hs_cnt[l];
                prio[l]     = 1'b0;
                last_a[l]   = '0;
                last_b[l]   = '0;
                last_op[l]  = '0;
            end else if (rst[l] && cyc >= rst_at[l] + 2) begin
                rst[l] = 1'b0;
            end
            for (int r = 0; r < 2; r++) begin
                if (acc_flag[l][r]) begin
                    v[l][r]        = 1'b0;
                    acc_flag[l][r] = 1'b0;
                end
                if (!rst[l] && !v[l][r] && pend[l][r].size() > 0) begin
                    req_t q;
                    q        = pend[l][r].pop_front();
                    v[l][r]  = 1'b1;
                    a[l][r]  = q.a;
                    b[l][r]  = q.b;
                    op[l][r] = q.op;
                end
            end
            resp_ready[l] = (rr_mode == 0) ? 1'b1 : (rr_mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
        end
        #1;
        for (int l = 0; l < 2; l++)
            if (cyc == rst_at[l]) check("reset_async_outputs", l, 64'(outs(l)), 64'h0);
        @(negedge clk);
        for (int l = 0; l < 2; l++) begin
            if (rst[l]) continue;
            if (busy(l)) begin
                e0 = 1'b0;
                e1 = 1'b0;
            end else if (v[l][0] && v[l][1]) begin
                e0 = !prio[l];
                e1 = prio[l];
            end else begin
                e0 = v[l][0];
                e1 = v[l][1];
            end
            check("req_ready", l, {62'h0, rdy[l][0], rdy[l][1]}, {62'h0, e0, e1});
            for (int r = 0; r < 2; r++)
                if (v[l][r] && rdy[l][r]) accept(l, r);
        end
    endtask

    task automatic drain(int budget);
        int n;
        n = 0;
        while (!idle() && n < budget) begin
            step();
            n++;
        end
        check("drain_timeout", 0, 64'(idle()), 64'h1);
    endtask

    task automatic push(int l, int r, logic [7:0] x, logic [7:0] y, logic [3:0] o);
        req_t q;
        q.a  = x;
        q.b  = y;
        q.op = o;
        pend[l][r].push_back(q);
    endtask

    // Response monitor: pops the scoreboard when a response first appears,
    // then watches it stay stable until the handshake.
    initial begin
        logic showing [2];
        logic hs      [2];
        exp_t e;
        logic [63:0] held [2];
        logic [63:0] now;
        showing[0] = 1'b0;
        showing[1] = 1'b0;
        forever begin
            @(negedge clk);
            for (int l = 0; l < 2; l++) begin
                hs[l] = 1'b0;
                if (rst[l]) begin
                    showing[l] = 1'b0;
                    continue;
                end
                now = {23'h0, resp_id[l], resp_res[l], resp_maior[l], resp_menor[l],
                       resp_igual[l], resp_erro[l], ula_a[l], ula_b[l], ula_op[l]};
                if (resp_valid[l]) begin
                    if (!showing[l]) begin
                        if (sb[l].size() == 0) begin
                            check("spurious_resp", l, 64'(resp_valid[l]), 64'h0);
                        end else begin
                            e = sb[l].pop_front();
                            check("resp_id", l, 64'(resp_id[l]), 64'(e.id));
                            check("resp_resultado", l, 64'(resp_res[l]), 64'(e.res));
                            check("resp_flags", l, {61'h0, resp_maior[l], resp_menor[l], resp_igual[l]},
                                  {61'h0, e.gt, e.lt, e.eq});
                            check("resp_erro", l, 64'(resp_erro[l]), 64'(e.err));
                            check("ula_inputs", l, {44'h0, ula_a[l], ula_b[l], ula_op[l]},
                                  {44'h0, e.ua, e.ub, e.uop});
                            check("resp_latency", l, 64'(cyc), 64'(e.due));
                        end
                        held[l]    = now;
                        showing[l] = 1'b1;
                    end else begin
                        check("resp_hold_stable", l, now, held[l]);
                    end
                    if (resp_ready[l]) begin
                        showing[l] = 1'b0;
                        hs[l]      = 1'b1;
                    end
                end else if (showing[l]) begin
                    check("resp_dropped", l, 64'(resp_valid[l]), 64'h1);
                    showing[l] = 1'b0;
                end
            end
            if (hs[0] || hs[1]) begin
                @(posedge clk);
                for (int l = 0; l < 2; l++) if (hs[l]) hs_cnt[l]++;
            end
        end
    end

    initial begin
        int n;
        rr_mode   = 0;
        reset_arm = 1'b0;
        for (int l = 0; l < 2; l++) begin
            rst[l]        = 1'b1;
            resp_ready[l] = 1'b0;
            acc_cnt[l]    = 0;
            hs_cnt[l]     = 0;
            drop_cnt[l]   = 0;
            rst_at[l]     = -1;
            prio[l]       = 1'b0;
            last_a[l]     = '0;
            last_b[l]     = '0;
            last_op[l]    = '0;
            for (int r = 0; r < 2; r++) begin
                v[l][r]        = 1'b0;
                acc_flag[l][r] = 1'b0;
                a[l][r]        = '0;
                b[l][r]        = '0;
                op[l][r]       = '0;
            end
        end
        repeat (3) @(posedge clk);
        #1;
        for (int l = 0; l < 2; l++) check("reset_outputs", l, 64'(outs(l)), 64'h0);
        @(negedge clk);
        for (int l = 0; l < 2; l++) rst[l] = 1'b0;

        // Both requesters at once straight after reset: req0 first, then req1.
        for (int l = 0; l < 2; l++) begin
            push(l, 0, 8'h10, 8'h10, 4'b0010);
            push(l, 1, 8'h02, 8'h07, 4'b0001);
        end
        drain(200);

        // Simple add, then divide-by-zero and undefined opcode, then a normal op.
        for (int l = 0; l < 2; l++) push(l, 0, 8'd5, 8'd3, 4'b0000);
        drain(200);
        for (int l = 0; l < 2; l++) push(l, 1, 8'd9, 8'd0, 4'b0011);
        drain(200);
        for (int l = 0; l < 2; l++) begin
            push(l, 0, 8'd1, 8'd1, 4'b0101);
            push(l, 0, 8'd200, 8'd7, 4'b0100);
        end
        drain(200);

        // Backpressure with both requesters waiting.
        for (int l = 0; l < 2; l++) begin
            push(l, 0, 8'h3C, 8'h0F, 4'b1010);
            push(l, 1, 8'h81, 8'h81, 4'b1000);
        end
        rr_mode = 1;
        repeat (12) step();
        rr_mode = 0;
        drain(200);

        // Randomised traffic with random response backpressure.
        for (int i = 0; i < 40; i++) begin
            for (int l = 0; l < 2; l++) begin
                push(l, int'($urandom_range(0, 1)), 8'($urandom),
                     ($urandom_range(0, 3) == 0) ? 8'h0 : 8'($urandom),
                     4'($urandom_range(0, 15)));
            end
        end
        rr_mode = 2;
        drain(3000);
        rr_mode = 0;

        // Reset while the ALU is busy; the in-flight op must vanish.
        reset_arm = 1'b1;
        for (int l = 0; l < 2; l++) push(l, 0, 8'h21, 8'h05, 4'b0001);
        n = 0;
        while (n < 50 && !(rst_at[0] >= 0 && rst_at[1] >= 0 && !rst[0] && !rst[1] &&
                           cyc > rst_at[0] + 2 && cyc > rst_at[1] + 2)) begin
            step();
            n++;
        end
        check("reset_phase_timeout", 0, 64'(n < 50), 64'h1);
        reset_arm = 1'b0;
        repeat (10) step();
        for (int l = 0; l < 2; l++) begin
            push(l, 0, 8'h44, 8'h11, 4'b0111);
            push(l, 1, 8'h06, 8'h06, 4'b1001);
        end
        drain(200);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ula_arbitro_2req.md
Name: ula_arbitro_2req

Overview:
Round-robin arbiter and sequencer that shares one ula_8bits instance between two requesters. It accepts one operation at a time over a valid/ready handshake and drives registered operands and Sel_Op into the ALU for LATENCIA cycles. It then captures Resultado and the comparator flags, and returns them on a single tagged response channel. Division by zero and undefined opcodes are rejected without using the ALU.

Parameters:
LATENCIA, 1, cycles ALU inputs are held stable before the result is captured (legal values 1..15).

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 operation accepted this cycle
req0_a  in  8  operand A
req0_b  in  8  operand B
req0_op  in  4  Sel_Op code
req1_valid / req1_ready / req1_a / req1_b / req1_op  same as requester 0
resp_valid  out  1  response available
resp_ready  in  1  consumer accepts response
resp_id  out  1  requester index (0 or 1)
resp_resultado  out  16  captured Resultado
resp_maior / resp_menor / resp_igual  out  1 each  captured comparator flags
resp_erro  out  1  operation rejected
ula_a / ula_b  out  8 each  to ALU A, B
ula_sel_op  out  4  to ALU Sel_Op
ula_resultado  in  16  from ALU
ula_maior / ula_menor / ula_igual  in  1 each  from ALU

Behaviour:
- Reset (async, immediate): state OCIOSO; prioridade=0; counter=0. All outputs 0, including ula_* and resp_*. An in-flight operation is discarded and no response is produced after reset is released.
- States: OCIOSO, EXECUTA, RESPOSTA.
- OCIOSO:
  - reqN_ready = reqN_valid AND grant N. At most one ready is high per cycle.
  - If both requesters are valid, the grant goes to prioridade.
  - After any accept, prioridade flips to the other requester.
- Accept at cycle T:
  - Latch a, b, op and id.
  - Valid ops are 0000-0100 and 0110-1011.
  - Error cases: op 0101 or 1100-1111, or op 0011/0100 with b==0. Go to RESPOSTA at T+1 with resp_erro=1, resultado=0, flags=0. ula_* outputs are not updated.
  - Otherwise, at T+1 ula_a/ula_b/ula_sel_op take the latched values and the state is EXECUTA.
- EXECUTA:
  - Counter runs 0..LATENCIA-1.
  - In the cycle where counter==LATENCIA-1, capture ula_resultado and flags into the resp registers and go to RESPOSTA.
  - resp_valid=1 at cycle T+1+LATENCIA.
  - ula_* outputs keep their last values after EXECUTA ends (no glitching to 0).
- RESPOSTA:
  - resp_* are held stable while resp_valid=1 and resp_ready=0.
  - Both req ready outputs are 0.
  - On resp_valid AND resp_ready: go to OCIOSO next cycle and drop resp_valid. resp_* data may hold its last value.
  - There is no accept in the same cycle as the response handshake. Minimum spacing between accepts is LATENCIA+2 cycles.
- Requester obligation: hold valid and payload stable until ready. Withdrawing valid before ready is legal; that request is simply not served.
- Simultaneous valid from both requesters with prioridade=1: req1 is served, then req0 on the next OCIOSO.

Decomposition:
- Shared include ula_defs.vh:
  - opcode constants OP_SOMA=0000, OP_SUB=0001, OP_MUL=0010, OP_DIV=0011, OP_RESTO=0100, OP_AND=0110, OP_OR=0111, OP_NAND=1000, OP_NOR=1001, OP_XOR=1010, OP_NOT=1011
  - state encodings
  - opcode-valid macro
- One sub-module, arbitro_rr_2: two valid inputs, enable, prioridade register, one-hot grant output.

Test Plan:
1. LATENCIA=1: req0 a=5, b=3, op=0000, accepted at T -> resp_valid at T+2, resultado=0x0008, id=0, maior=1, erro=0.
2. After reset, both valid: req0 a=0x10, b=0x10, op=0010; req1 a=2, b=7, op=0001 -> first response id=0, resultado=0x0100, igual=1. Second response id=1, resultado=0xFFFB, menor=1.
3. req1 a=9, b=0, op=0011 -> resp_valid at T+1, erro=1, resultado=0, flags 0, ula_sel_op unchanged from previous op.
4. req0 op=0101, a=1, b=1 -> erro=1. Next valid op is still served normally.
5. Backpressure: hold resp_ready=0 for 5 cycles with both req valid -> resp_* stable, both req ready=0. Release -> OCIOSO next cycle, the other requester is granted.
6. Assert rst during EXECUTA with LATENCIA=4 -> all outputs 0 in the same cycle. After release, no resp_valid for 10 cycles without new requests, and prioridade=0.
